// File: rtl/icb_conv_arbiter.sv
// Two-master, one-slave ICB arbiter: CPU data port (m0) and conv engine (m1) share one memory path.
// Define ICB_ARB_RR_EN for round-robin tie-breaking; the default build uses fixed priority with m0 winning ties.
module icb_conv_arbiter #(
  parameter int OUTS_DEPTH = 4,
  parameter int AW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [31:0]   m0_icb_cmd_wdata,
  input  logic [3:0]    m0_icb_cmd_wmask,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [31:0]   m0_icb_rsp_rdata,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [31:0]   m1_icb_cmd_wdata,
  input  logic [3:0]    m1_icb_cmd_wmask,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [31:0]   m1_icb_rsp_rdata,

  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic          s_icb_cmd_read,
  output logic [31:0]   s_icb_cmd_wdata,
  output logic [3:0]    s_icb_cmd_wmask,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [31:0]   s_icb_rsp_rdata,

  output logic          arb_err
);

  localparam int PW = $clog2(OUTS_DEPTH);
  localparam int CW = $clog2(OUTS_DEPTH + 1);

`ifdef ICB_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic                  lock;
  logic                  lock_id;
  logic                  rr_last;
  logic [OUTS_DEPTH-1:0] id_fifo;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         cnt;

  logic full;
  logic empty;
  logic gnt;
  logic gnt_valid;
  logic head;
  logic push;
  logic pop;

  // full uses the registered count, so a same-cycle pop frees its slot only next cycle
  assign full  = (cnt == CW'(OUTS_DEPTH));
  assign empty = (cnt == '0);

  always_comb begin
    gnt = 1'b0;
    if (lock)
      gnt = lock_id;
    else if (m0_icb_cmd_valid && m1_icb_cmd_valid)
      gnt = RR_EN ? ~rr_last : 1'b0;
    else
      gnt = m1_icb_cmd_valid;
  end

  assign gnt_valid        = gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign s_icb_cmd_valid  = gnt_valid & ~full;
  assign s_icb_cmd_addr   = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read   = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata  = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask  = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign m0_icb_cmd_ready = ~gnt & s_icb_cmd_ready & ~full;
  assign m1_icb_cmd_ready =  gnt & s_icb_cmd_ready & ~full;

  assign head             = id_fifo[rptr];
  assign m0_icb_rsp_valid = s_icb_rsp_valid & ~empty & ~head;
  assign m1_icb_rsp_valid = s_icb_rsp_valid & ~empty &  head;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  // with nothing outstanding a stray response is sunk rather than stalling the slave
  assign s_icb_rsp_ready  = empty ? 1'b1 : (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

  assign push = s_icb_cmd_valid & s_icb_cmd_ready;
  assign pop  = s_icb_rsp_valid & s_icb_rsp_ready & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      lock_id <= 1'b0;
      rr_last <= 1'b1;
      id_fifo <= '0;
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      arb_err <= 1'b0;
    end else begin
      if (s_icb_cmd_valid) begin
        if (s_icb_cmd_ready) begin
          lock          <= 1'b0;
          rr_last       <= gnt;
          id_fifo[wptr] <= gnt;
          wptr          <= wptr + 1'b1;
        end else begin
          lock    <= 1'b1;
          lock_id <= gnt;
        end
      end
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      if (s_icb_rsp_valid && empty)
        arb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icb_conv_arbiter.sv
// Bench for icb_conv_arbiter: queue-based reference model checked every cycle, directed scenarios, random traffic.
module tb_icb_conv_arbiter;
  localparam int D = 4;

`ifdef ICB_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mv  [2];
  logic [31:0] ma  [2];
  logic        mr  [2];
  logic [31:0] mw  [2];
  logic [3:0]  mm  [2];
  logic        mrr [2];
  logic        s_cmd_ready, s_rsp_valid;
  logic [31:0] s_rsp_rdata;

  logic        m0_icb_cmd_ready, m1_icb_cmd_ready, m0_icb_rsp_valid, m1_icb_rsp_valid;
  logic [31:0] m0_icb_rsp_rdata, m1_icb_rsp_rdata;
  logic        s_icb_cmd_valid, s_icb_cmd_read, s_icb_rsp_ready, arb_err;
  logic [31:0] s_icb_cmd_addr, s_icb_cmd_wdata;
  logic [3:0]  s_icb_cmd_wmask;

  always #5 clk = ~clk;

  icb_conv_arbiter #(.OUTS_DEPTH(D), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(mv[0]), .m0_icb_cmd_ready(m0_icb_cmd_ready), .m0_icb_cmd_addr(ma[0]),
    .m0_icb_cmd_read(mr[0]), .m0_icb_cmd_wdata(mw[0]), .m0_icb_cmd_wmask(mm[0]),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(mrr[0]), .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(mv[1]), .m1_icb_cmd_ready(m1_icb_cmd_ready), .m1_icb_cmd_addr(ma[1]),
    .m1_icb_cmd_read(mr[1]), .m1_icb_cmd_wdata(mw[1]), .m1_icb_cmd_wmask(mm[1]),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(mrr[1]), .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_cmd_ready), .s_icb_cmd_addr(s_icb_cmd_addr),
    .s_icb_cmd_read(s_icb_cmd_read), .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready), .s_icb_rsp_rdata(s_rsp_rdata),
    .arb_err(arb_err)
  );

  int n_chk, n_fail;

  // reference model: outstanding owner IDs, slave-side and per-master address queues
  bit          lock, lock_id, rr_last, err;
  bit          q   [$];
  logic [31:0] sq  [$];
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  logic [31:0] got0 [$];
  logic [31:0] got1 [$];
  bit          acc [2];
  bit          popped;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    lock = 0; lock_id = 0; rr_last = 1; err = 0;
    q.delete(); sq.delete(); mq0.delete(); mq1.delete(); got0.delete(); got1.delete();
    acc[0] = 0; acc[1] = 0; popped = 0;
  endfunction

  // called at a negedge with inputs already driven; checks, then advances the model at the posedge
  task automatic cycle();
    bit full, empty, g, sv, head, srr, pop, push;
    logic [31:0] e;
    #2;
    full  = (q.size() == D);
    empty = (q.size() == 0);
    if (lock) g = lock_id;
    else if (mv[0] && mv[1]) g = RR ? !rr_last : 1'b0;
    else g = mv[1];
    sv = mv[g] && !full;
    chk1("s_cmd_valid", s_icb_cmd_valid, sv);
    chk1("m0_cmd_ready", m0_icb_cmd_ready, !g && s_cmd_ready && !full);
    chk1("m1_cmd_ready", m1_icb_cmd_ready, g && s_cmd_ready && !full);
    if (sv) begin
      chk32("s_cmd_addr", s_icb_cmd_addr, ma[g]);
      chk1("s_cmd_read", s_icb_cmd_read, mr[g]);
      chk32("s_cmd_wdata", s_icb_cmd_wdata, mw[g]);
      chk32("s_cmd_wmask", {28'd0, s_icb_cmd_wmask}, {28'd0, mm[g]});
    end
    head = empty ? 1'b0 : q[0];
    srr  = empty ? 1'b1 : mrr[head];
    chk1("m0_rsp_valid", m0_icb_rsp_valid, s_rsp_valid && !empty && !head);
    chk1("m1_rsp_valid", m1_icb_rsp_valid, s_rsp_valid && !empty && head);
    chk1("s_rsp_ready", s_icb_rsp_ready, srr);
    chk1("arb_err", arb_err, err);
    pop  = s_rsp_valid && srr && !empty;
    push = sv && s_cmd_ready;
    if (pop) begin
      if (!head) begin
        e = (mq0.size() > 0) ? mq0.pop_front() : 32'hx;
        chk32("m0_rsp_order", m0_icb_rsp_rdata, e);
        got0.push_back(m0_icb_rsp_rdata);
      end else begin
        e = (mq1.size() > 0) ? mq1.pop_front() : 32'hx;
        chk32("m1_rsp_order", m1_icb_rsp_rdata, e);
        got1.push_back(m1_icb_rsp_rdata);
      end
    end
    @(posedge clk);
    if (sv && !s_cmd_ready) begin lock = 1; lock_id = g; end
    if (push) begin
      lock = 0; rr_last = g; q.push_back(g); sq.push_back(ma[g]);
      if (g) mq1.push_back(ma[g]); else mq0.push_back(ma[g]);
    end
    if (pop) begin void'(q.pop_front()); void'(sq.pop_front()); end
    if (s_rsp_valid && empty) err = 1;
    acc[0] = push && !g;
    acc[1] = push && g;
    popped = pop || (s_rsp_valid && empty);
    @(negedge clk);
  endtask

  // slave echoes the address of the oldest accepted command as rdata; holds valid until taken
  task automatic drive_slave(input int p_cr, input int p_rv);
    s_cmd_ready = ($urandom % 100) < p_cr;
    if (!(s_rsp_valid && !popped)) begin
      if (sq.size() > 0 && ($urandom % 100) < p_rv) begin
        s_rsp_valid = 1; s_rsp_rdata = sq[0];
      end else begin
        s_rsp_valid = 0; s_rsp_rdata = $urandom;
      end
    end
  endtask

  task automatic drive_masters(input int p_new, input int p_rr);
    for (int m = 0; m < 2; m++) begin
      if (!mv[m] || acc[m]) begin
        mv[m] = ($urandom % 100) < p_new;
        ma[m] = $urandom; mr[m] = $urandom % 2; mw[m] = $urandom; mm[m] = 4'($urandom);
      end
      mrr[m] = ($urandom % 100) < p_rr;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; ma[m] = 0; mr[m] = 1; mw[m] = 0; mm[m] = 4'hf; mrr[m] = 0;
    end
    s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    int idx, n_acc;
    n_chk = 0; n_fail = 0;
    do_reset();

    // reset state
    #1;
    chk1("rst_s_cmd_valid", s_icb_cmd_valid, 1'b0);
    chk1("rst_m0_cmd_ready", m0_icb_cmd_ready, 1'b0);
    chk1("rst_m1_cmd_ready", m1_icb_cmd_ready, 1'b0);
    chk1("rst_m0_rsp_valid", m0_icb_rsp_valid, 1'b0);
    chk1("rst_arb_err", arb_err, 1'b0);
    cycle();

    // single master m1: 8 reads, slave echoes address
    idx = 0;
    for (int c = 0; c < 40 && got1.size() < 8; c++) begin
      drive_slave(100, 100);
      mv[1] = (idx < 8); ma[1] = 32'h4000_0000 + idx * 4; mr[1] = 1; mrr[1] = 1; mrr[0] = 1;
      cycle();
      if (acc[1]) idx++;
    end
    chk32("single_m1_count", got1.size(), 8);
    chk32("single_m0_count", got0.size(), 0);
    if (got1.size() == 8)
      for (int i = 0; i < 8; i++) chk32("single_rdata", got1[i], 32'h4000_0000 + i * 4);

    // tie with 3 stall cycles
    do_reset();
    mv[0] = 1; ma[0] = 32'h100; mv[1] = 1; ma[1] = 32'h200;
    for (int c = 0; c < 4; c++) begin
      s_cmd_ready = (c == 3);
      #1;
      chk32("tie_addr_held", s_icb_cmd_addr, 32'h100);
      chk1("tie_m1_ready", m1_icb_cmd_ready, 1'b0);
      cycle();
    end
    chk1("tie_m0_accepted", acc[0], 1'b1);
    ma[0] = 32'h104;
    #1 chk32("tie_next_grant", s_icb_cmd_addr, RR ? 32'h200 : 32'h104);
    cycle();

    // full: 5 commands, no responses until one pop
    do_reset();
    s_cmd_ready = 1; mv[0] = 1; mrr[0] = 1; n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      ma[0] = 32'h1000 + c * 4;
      cycle();
      n_acc += int'(acc[0]);
    end
    chk32("full_accepted", n_acc, 4);
    ma[0] = 32'h1010;
    repeat (2) begin
      #1 chk1("full_ready_low", m0_icb_cmd_ready, 1'b0);
      cycle();
    end
    drive_slave(100, 100);
    #1;
    chk1("full_pop_cycle_ready", m0_icb_cmd_ready, 1'b0);
    chk32("full_pop_rdata", m0_icb_rsp_rdata, 32'h1000);
    cycle();
    drive_slave(100, 0);
    #1 chk1("full_after_pop_ready", m0_icb_cmd_ready, 1'b1);
    cycle();
    chk1("full_5th_accepted", acc[0], 1'b1);

    // interleaved routing m0,m1,m1,m0
    do_reset();
    mrr[0] = 1; mrr[1] = 1;
    for (int c = 0; c < 4; c++) begin
      drive_slave(100, 0);
      mv[0] = (c == 0 || c == 3); mv[1] = (c == 1 || c == 2);
      ma[0] = (c == 0) ? 32'h11 : 32'h44;
      ma[1] = (c == 1) ? 32'h22 : 32'h33;
      cycle();
    end
    mv[0] = 0; mv[1] = 0;
    for (int c = 0; c < 8; c++) begin
      drive_slave(100, 100);
      mrr[1] = !(c == 1 || c == 2);
      if (c == 1 || c == 2) begin
        #1;
        chk1("stall_s_rsp_ready", s_icb_rsp_ready, 1'b0);
        chk1("stall_m1_rsp_valid", m1_icb_rsp_valid, 1'b1);
      end
      cycle();
    end
    chk32("route_m0_count", got0.size(), 2);
    chk32("route_m1_count", got1.size(), 2);
    if (got0.size() == 2) begin
      chk32("route_m0_first", got0[0], 32'h11);
      chk32("route_m0_second", got0[1], 32'h44);
    end
    if (got1.size() == 2) begin
      chk32("route_m1_first", got1[0], 32'h22);
      chk32("route_m1_second", got1[1], 32'h33);
    end

    // protocol error, then reset with 2 outstanding and m1 locked
    do_reset();
    s_rsp_valid = 1; s_rsp_rdata = 32'hdead_beef;
    #1;
    chk1("err_m0_rsp_valid", m0_icb_rsp_valid, 1'b0);
    chk1("err_m1_rsp_valid", m1_icb_rsp_valid, 1'b0);
    chk1("err_dropped_ready", s_icb_rsp_ready, 1'b1);
    cycle();
    s_rsp_valid = 0;
    #1 chk1("err_sticky", arb_err, 1'b1);
    cycle();
    s_cmd_ready = 1; mv[0] = 1; ma[0] = 32'h500;
    cycle();
    ma[0] = 32'h504;
    cycle();
    mv[0] = 0; mv[1] = 1; ma[1] = 32'h600; s_cmd_ready = 0;
    cycle();
    rst_n = 0; mv[1] = 0; mv[0] = 1; ma[0] = 32'ha0; mrr[0] = 0;
    #1;
    chk1("rst_err_cleared", arb_err, 1'b0);
    chk1("rst_fifo_empty", s_icb_rsp_ready, 1'b1);
    chk1("rst_unlocked_valid", s_icb_cmd_valid, 1'b1);
    chk32("rst_unlocked_addr", s_icb_cmd_addr, 32'ha0);

    // random traffic in three pressure profiles
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      for (int c = 0; c < 1500; c++) begin
        case (seg)
          0:       begin drive_slave(70, 60); drive_masters(70, 80); end
          1:       begin drive_slave(90, 15); drive_masters(90, 50); end
          default: begin drive_slave(40, 90); drive_masters(50, 90); end
        endcase
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/icb_conv_arbiter.md
# icb_conv_arbiter

- Two-master, one-slave ICB arbiter.
- Lets the CPU data port (m0) and the conv engine master port (m1) share the single ICB path to the weight/input/output memory region.
- Forwards commands with zero added latency and holds the grant until the command handshakes.
- Routes in-order responses back to the issuing master through an outstanding-ID FIFO.

## Interface
Parameters:
- OUTS_DEPTH, 4: max outstanding commands (power of 2, ≥2); response-ID FIFO depth.
- AW, 32: address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_icb_cmd_valid / m1_icb_cmd_valid  in  1  master command valid.
- m0_icb_cmd_ready / m1_icb_cmd_ready  out  1  master command ready.
- m0_icb_cmd_addr / m1_icb_cmd_addr  in  AW  address.
- m0_icb_cmd_read / m1_icb_cmd_read  in  1  1 = read, 0 = write.
- m0_icb_cmd_wdata / m1_icb_cmd_wdata  in  32  write data.
- m0_icb_cmd_wmask / m1_icb_cmd_wmask  in  4  byte mask.
- m0_icb_rsp_valid / m1_icb_rsp_valid  out  1  response valid.
- m0_icb_rsp_ready / m1_icb_rsp_ready  in  1  response ready.
- m0_icb_rsp_rdata / m1_icb_rsp_rdata  out  32  read data.
- s_icb_cmd_valid, s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask  out  1/AW/1/32/4  downstream command.
- s_icb_cmd_ready  in  1  downstream ready.
- s_icb_rsp_valid  in  1;  s_icb_rsp_rdata  in  32;  s_icb_rsp_ready  out  1.
- arb_err  out  1  sticky: a response arrived with no outstanding command.

## Operation
- Grant state: `lock` (1 bit), `lock_id` (1 bit), `rr_last` (1 bit), ID FIFO (OUTS_DEPTH × 1 bit), `cnt` ($clog2(OUTS_DEPTH+1) bits).
- Selection:
  - If `lock`=1, gnt = `lock_id`.
  - Otherwise, among the valid masters, gnt per the arbitration policy (Configuration). With a single valid master, that master is granted.
- Command forwarding:
  - s_cmd_* = granted master's cmd fields.
  - s_cmd_valid = granted valid & ~full (full: `cnt`==OUTS_DEPTH).
  - Granted master's cmd_ready = s_cmd_ready & ~full. Non-granted master's cmd_ready = 0.
- Lock:
  - On s_cmd_valid & ~s_cmd_ready: set `lock`=1, `lock_id`=gnt.
  - On s_cmd_valid & s_cmd_ready: clear `lock`, push gnt into the FIFO, set `rr_last`=gnt.
  - While full, `lock` is unchanged.
- Response routing:
  - head = FIFO head ID.
  - m{head}_rsp_valid = s_rsp_valid & ~empty; other master's rsp_valid = 0.
  - rsp_rdata goes to both masters.
  - s_rsp_ready = m{head}_rsp_ready when not empty; 1 when empty.
  - Pop on s_rsp_valid & s_rsp_ready & ~empty.
- Simultaneous push and pop: `cnt` is unchanged; both pointers advance.
- Full/pop interaction: full is evaluated on the registered `cnt`. A pop in the same cycle does not open a slot until the next cycle.
- Protocol error: s_rsp_valid while empty → response dropped (s_rsp_ready=1), arb_err set to 1; cleared only by reset.
- Write responses are routed identically to read responses (ICB returns one rsp per cmd).

## Timing
- Reset values:
  - Registers: `lock`=0, `lock_id`=0, `rr_last`=1 (so m0 wins first RR tie), FIFO empty, `cnt`=0, arb_err=0.
  - Outputs during/after reset: all cmd_ready and rsp_valid are 0 until inputs drive them; s_cmd_valid=0 with no master valid.
- Latency: command path combinational, 0 cycles valid→s_cmd_valid. Response path combinational, 0 cycles.
- Grant switch: earliest in the cycle after the locked command handshakes. A non-granted master waits; its valid is required to stay asserted (ICB rule).
- Back-to-back: one command per cycle sustained while not full; both masters can interleave every cycle.
- `cnt` wrap: FIFO pointers are $clog2(OUTS_DEPTH) bits and wrap modulo depth.
- Reset mid-transaction: all outstanding IDs are discarded. Downstream is reset by the same rst_n.

## Configuration
- `ICB_ARB_RR_EN`
  - Defined: round-robin. On a tie the master ≠ `rr_last` wins.
  - Undefined: fixed priority, m0 (CPU) always wins ties; `rr_last` is still maintained but unused.

## Test plan
- Single master: m1 issues 8 reads to 0x4000_0000..0x4000_001C, s_cmd_ready=1, slave returns rdata=addr one cycle later → m1 receives 8 responses in order, m0_rsp_valid never 1.
- Tie with stall: m0 and m1 valid in cycle 0, s_cmd_ready=0 for 3 cycles → s_cmd_addr is held on m0's address for all 4 cycles, m1_cmd_ready=0. Then:
  - RR: next grant m1.
  - Fixed, m0 still valid: m0 again.
- Full: OUTS_DEPTH=4, slave withholds rsp; 5 commands offered → exactly 4 accepted, 5th cmd_ready=0 until one rsp pops, accepted the cycle after the pop.
- Interleaved routing: cmd order m0,m1,m1,m0 with rdata 0x11,0x22,0x33,0x44 → m0 gets 0x11,0x44; m1 gets 0x22,0x33. m1_rsp_ready=0 for 2 cycles stalls s_rsp_ready.
- Error/reset: s_rsp_valid with FIFO empty → arb_err=1, no master rsp_valid. Assert rst_n low with 2 outstanding → `cnt`=0, arb_err=0, lock=0 immediately.
